// File: rtl/id_hazard_ctrl.sv
// id_hazard_ctrl: per-register pending-write scoreboard and ID-stage issue control.
// Optional build macro SCOREBOARD_BYPASS_EN: a source whose last pending write retires this cycle may issue.
module id_hazard_ctrl #(
  parameter int unsigned CNT_W = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  id_rd,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic        id_wr_rd,
  input  logic        ex_ready,
  input  logic        flush,
  input  logic        wb_valid,
  input  logic [4:0]  wb_addr,
  output logic        issue,
  output logic        stall,
  output logic [31:0] busy,
  output logic [6:0]  inflight,
  output logic        err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt [32];
  logic [CNT_W-1:0] cnt_rs1;
  logic [CNT_W-1:0] cnt_rs2;
  logic [CNT_W-1:0] cnt_rd;
  logic [CNT_W-1:0] cnt_wb;
  logic             haz_rs1;
  logic             haz_rs2;
  logic             haz_rd;
  logic             hazard;
  logic [31:0]      inc_vec;
  logic [31:0]      dec_vec;
  logic             inc_any;
  logic             dec_any;
  logic             wb_orphan;

  assign cnt_rs1 = cnt[id_rs1];
  assign cnt_rs2 = cnt[id_rs2];
  assign cnt_rd  = cnt[id_rd];
  assign cnt_wb  = cnt[wb_addr];

  always_comb begin
    haz_rs1 = id_use_rs1 && (id_rs1 != '0) && (cnt_rs1 != '0);
    haz_rs2 = id_use_rs2 && (id_rs2 != '0) && (cnt_rs2 != '0);
`ifdef SCOREBOARD_BYPASS_EN
    // Write-through regfile: the final pending write lands on the read port this cycle.
    if ((cnt_rs1 == CNT_ONE) && wb_valid && (wb_addr == id_rs1))
      haz_rs1 = 1'b0;
    if ((cnt_rs2 == CNT_ONE) && wb_valid && (wb_addr == id_rs2))
      haz_rs2 = 1'b0;
`endif
    haz_rd = id_wr_rd && (id_rd != '0) && (cnt_rd == CNT_MAX);
    hazard = haz_rs1 || haz_rs2 || haz_rd;
  end

  // Gated by rst so nothing issues or stalls while the scoreboard is being cleared.
  assign issue = !rst && id_valid && ex_ready && !hazard && !flush;
  assign stall = !rst && id_valid && !issue && !flush;

  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    for (int unsigned r = 1; r < 32; r++) begin
      inc_vec[r] = issue && id_wr_rd && (id_rd == 5'(r));
      dec_vec[r] = wb_valid && (wb_addr == 5'(r)) && (cnt[r] != '0);
    end
  end

  assign inc_any   = |inc_vec;
  assign dec_any   = |dec_vec;
  assign wb_orphan = wb_valid && (wb_addr != '0) && (cnt_wb == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned r = 0; r < 32; r++)
        cnt[r] <= '0;
      inflight <= '0;
      err      <= 1'b0;
    end else begin
      cnt[0] <= '0;
      for (int unsigned r = 1; r < 32; r++) begin
        if (inc_vec[r] && !dec_vec[r])
          cnt[r] <= cnt[r] + CNT_ONE;
        else if (dec_vec[r] && !inc_vec[r])
          cnt[r] <= cnt[r] - CNT_ONE;
      end
      // At most one inc and one dec per cycle, possibly on different registers.
      if (inc_any && !dec_any)
        inflight <= inflight + 7'd1;
      else if (dec_any && !inc_any)
        inflight <= inflight - 7'd1;
      if (wb_orphan)
        err <= 1'b1;
    end
  end

  always_comb begin
    busy = '0;
    for (int unsigned r = 1; r < 32; r++)
      busy[r] = (cnt[r] != '0);
  end

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// tb_id_hazard_ctrl: directed vectors; expectations queued by stimulus, checked by a negedge monitor.
module tb_id_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [4:0]  id_rd;
  logic        id_use_rs1;
  logic        id_use_rs2;
  logic        id_wr_rd;
  logic        ex_ready;
  logic        flush;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic        issue;
  logic        stall;
  logic [31:0] busy;
  logic [6:0]  inflight;
  logic        err;

  localparam int SEL_ISSUE = 0;
  localparam int SEL_STALL = 1;
  localparam int SEL_BUSY  = 2;
  localparam int SEL_INFL  = 3;
  localparam int SEL_ERR   = 4;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] val;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  id_hazard_ctrl #(.CNT_W(2)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_wr_rd(id_wr_rd),
    .ex_ready(ex_ready), .flush(flush), .wb_valid(wb_valid), .wb_addr(wb_addr),
    .issue(issue), .stall(stall), .busy(busy), .inflight(inflight), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running required finished");
    $fatal(1, "timeout");
  end

  // Monitor: every queued expectation is compared at the negedge of its cycle.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t        e;
      logic [31:0] act;
      e = q.pop_front();
      case (e.sel)
        SEL_ISSUE: act = {31'b0, issue};
        SEL_STALL: act = {31'b0, stall};
        SEL_BUSY:  act = busy;
        SEL_INFL:  act = {25'b0, inflight};
        default:   act = {31'b0, err};
      endcase
      n_cmp++;
      if (act !== e.val) begin
        n_bad++;
        $display("FAIL %s: got %0h required %0h", e.name, act, e.val);
      end
    end
  end

  task automatic chk(input string name, input int sel, input logic [31:0] val);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.val  = val;
    q.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
    id_use_rs1 = 0; id_use_rs2 = 0; id_wr_rd = 0;
    ex_ready = 0; flush = 0; wb_valid = 0; wb_addr = 0;
  endtask

  task automatic instr(input logic [4:0] rs1, input logic use1, input logic [4:0] rd,
                       input logic wr, input logic rdy);
    id_valid = 1; id_rs1 = rs1; id_use_rs1 = use1; id_rs2 = 0; id_use_rs2 = 0;
    id_rd = rd; id_wr_rd = wr; ex_ready = rdy; flush = 0;
  endtask

  initial begin
    rst = 1;
    idle_in();

    // Reset held: outputs cleared, nothing issues or stalls.
    cyc();
    instr(5'd5, 1, 5'd0, 0, 1);
    chk("rst_issue", SEL_ISSUE, 0);
    chk("rst_stall", SEL_STALL, 0);
    chk("rst_busy", SEL_BUSY, 0);
    chk("rst_inflight", SEL_INFL, 0);
    chk("rst_err", SEL_ERR, 0);

    cyc();
    rst = 0;
    chk("idle_issue", SEL_ISSUE, 1);
    chk("idle_stall", SEL_STALL, 0);

    // RAW on x7.
    cyc();
    instr(5'd0, 0, 5'd7, 1, 1);
    chk("raw_wr_issue", SEL_ISSUE, 1);
    cyc();
    instr(5'd7, 1, 5'd0, 0, 1);
    chk("raw_busy7", SEL_BUSY, 32'h0000_0080);
    chk("raw_inflight1", SEL_INFL, 1);
    chk("raw_stall_a", SEL_STALL, 1);
    chk("raw_issue_a", SEL_ISSUE, 0);
    cyc();
    chk("raw_stall_b", SEL_STALL, 1);
    cyc();
    wb_valid = 1; wb_addr = 5'd7;
`ifdef SCOREBOARD_BYPASS_EN
    chk("raw_wb_issue", SEL_ISSUE, 1);
    chk("raw_wb_stall", SEL_STALL, 0);
`else
    chk("raw_wb_issue", SEL_ISSUE, 0);
    chk("raw_wb_stall", SEL_STALL, 1);
`endif
    cyc();
    wb_valid = 0; wb_addr = 0;
    chk("raw_after_issue", SEL_ISSUE, 1);
    chk("raw_after_busy", SEL_BUSY, 0);
    chk("raw_after_inflight", SEL_INFL, 0);

    // x0 is never tracked.
    cyc();
    instr(5'd0, 0, 5'd0, 1, 1);
    chk("x0_wr_issue", SEL_ISSUE, 1);
    cyc();
    instr(5'd0, 1, 5'd0, 0, 1);
    wb_valid = 1; wb_addr = 5'd0;
    chk("x0_rd_issue", SEL_ISSUE, 1);
    chk("x0_busy", SEL_BUSY, 0);
    chk("x0_inflight", SEL_INFL, 0);
    cyc();
    idle_in();
    chk("x0_err", SEL_ERR, 0);
    chk("x0_busy_after", SEL_BUSY, 0);
    chk("x0_inflight_after", SEL_INFL, 0);

    // Saturation of x3.
    cyc();
    instr(5'd0, 0, 5'd3, 1, 1);
    chk("sat_issue1", SEL_ISSUE, 1);
    cyc();
    chk("sat_inflight1", SEL_INFL, 1);
    chk("sat_issue2", SEL_ISSUE, 1);
    cyc();
    chk("sat_inflight2", SEL_INFL, 2);
    chk("sat_issue3", SEL_ISSUE, 1);
    cyc();
    chk("sat_inflight3", SEL_INFL, 3);
    chk("sat_busy3", SEL_BUSY, 32'h0000_0008);
    chk("sat_stall4", SEL_STALL, 1);
    chk("sat_issue4", SEL_ISSUE, 0);
    cyc();
    wb_valid = 1; wb_addr = 5'd3;
    chk("sat_wb_stall", SEL_STALL, 1);
    chk("sat_wb_issue", SEL_ISSUE, 0);
    cyc();
    wb_valid = 0; wb_addr = 0;
    chk("sat_rel_inflight", SEL_INFL, 2);
    chk("sat_rel_issue", SEL_ISSUE, 1);
    cyc();
    idle_in();
    chk("sat_final_inflight", SEL_INFL, 3);
    chk("sat_final_busy", SEL_BUSY, 32'h0000_0008);

    // Simultaneous inc/dec on x9.
    cyc();
    instr(5'd0, 0, 5'd9, 1, 1);
    chk("sim_issue_a", SEL_ISSUE, 1);
    cyc();
    idle_in();
    chk("sim_inflight_a", SEL_INFL, 4);
    chk("sim_busy_a", SEL_BUSY, 32'h0000_0208);
    cyc();
    instr(5'd0, 0, 5'd9, 1, 1);
    wb_valid = 1; wb_addr = 5'd9;
    chk("sim_issue_b", SEL_ISSUE, 1);
    cyc();
    idle_in();
    chk("sim_inflight_b", SEL_INFL, 4);
    chk("sim_busy_b", SEL_BUSY, 32'h0000_0208);
    chk("sim_err", SEL_ERR, 0);

    // Flush drops the instruction even with a pending hazard.
    cyc();
    instr(5'd3, 1, 5'd10, 1, 1);
    flush = 1;
    chk("flush_issue", SEL_ISSUE, 0);
    chk("flush_stall", SEL_STALL, 0);
    cyc();
    idle_in();
    chk("flush_inflight", SEL_INFL, 4);
    chk("flush_busy", SEL_BUSY, 32'h0000_0208);

    // EX not ready, no hazard.
    cyc();
    instr(5'd0, 0, 5'd11, 1, 0);
    chk("exnr_issue", SEL_ISSUE, 0);
    chk("exnr_stall", SEL_STALL, 1);
    cyc();
    idle_in();
    chk("exnr_inflight", SEL_INFL, 4);
    chk("exnr_busy", SEL_BUSY, 32'h0000_0208);

    // Writeback to an idle register sets sticky err.
    cyc();
    wb_valid = 1; wb_addr = 5'd12;
    chk("err_same_cycle", SEL_ERR, 0);
    cyc();
    idle_in();
    chk("err_set", SEL_ERR, 1);
    chk("err_busy", SEL_BUSY, 32'h0000_0208);
    cyc();
    chk("err_sticky", SEL_ERR, 1);
    chk("err_inflight", SEL_INFL, 4);

    // Asynchronous reset between edges.
    cyc();
    instr(5'd0, 0, 5'd0, 0, 1);
    #1;
    rst = 1;
    chk("arst_err", SEL_ERR, 0);
    chk("arst_busy", SEL_BUSY, 0);
    chk("arst_inflight", SEL_INFL, 0);
    chk("arst_issue", SEL_ISSUE, 0);
    chk("arst_stall", SEL_STALL, 0);
    cyc();
    rst = 0;
    idle_in();
    chk("post_rst_busy", SEL_BUSY, 0);

    cyc();
    cyc();
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL queue_drain: got %0d pending required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
